// File: rtl/button_input_pkg.sv
// Shared I/O definitions for memory-mapped peripherals on the 8-bit CPU bus:
// register offsets, default base address and the address decode helper.
package button_input_pkg;

  localparam logic [7:0] DEFAULT_BASE_ADDR = 8'h0B;
  localparam logic [7:0] STATUS_OFFSET     = 8'h00;
  localparam logic [7:0] EVENT_OFFSET      = 8'h01;

  typedef enum logic [1:0] {
    SEL_STATUS,
    SEL_EVENT,
    SEL_NONE
  } reg_sel_e;

  // Offset is taken modulo 256, so a base of 8'hFF places EVENT at 8'h00.
  function automatic reg_sel_e decode_addr(input logic [7:0] addr,
                                           input logic [7:0] base);
    logic [7:0] offset;
    offset = addr - base;
    if (offset == STATUS_OFFSET)     return SEL_STATUS;
    else if (offset == EVENT_OFFSET) return SEL_EVENT;
    else                             return SEL_NONE;
  endfunction

endpackage

// File: rtl/button_input_if.sv
// 8-bit CPU I/O bus: address, write strobe, write data and read data.
interface button_input_if #(
  parameter int DATA_W = 8
);
  logic [7:0]        addr;
  logic              write_en;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] dout;

  modport master (output addr, output write_en, output din, input dout);
  modport slave  (input addr, input write_en, input din, output dout);
endinterface

// File: rtl/button_input_debounce_bit.sv
// One input channel: two-flop synchroniser, hold-time debounce counter,
// qualified stable level and a single-cycle pulse on each 0->1 qualification.
module debounce_bit #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_WIDTH       = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_stable,
  output logic o_rise
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic                 r_sync1;
  logic                 r_sync2;
  logic                 r_stable;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 w_qualify;

  // Asserted in the cycle before stable flips, so the event lands on the same edge.
  assign w_qualify = (r_sync2 != r_stable) && (r_cnt == CNT_MAX);
  assign o_rise    = w_qualify && r_sync2;
  assign o_stable  = r_stable;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_stable) begin
        r_cnt <= '0;
      end else if (w_qualify) begin
        r_stable <= r_sync2;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/button_input.sv
// Memory-mapped button input port: debounced STATUS levels plus a sticky,
// write-1-to-clear EVENT register of press events with a pending flag.
module button_input
  import button_input_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR       = DEFAULT_BASE_ADDR,
  parameter int         data_width      = 8,
  parameter int         DEBOUNCE_CYCLES = 16,
  parameter int         CNT_WIDTH       = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  button_input_if.slave         bus,
  input  logic [data_width-1:0] i_btn_in,
  output logic                  o_event_pend
);

  logic [data_width-1:0] w_stable;
  logic [data_width-1:0] w_rise;
  logic [data_width-1:0] w_clr_mask;
  logic [data_width-1:0] w_event_next;
  logic [data_width-1:0] r_event;
  logic                  r_event_pend;
  reg_sel_e              w_sel;

  for (genvar i = 0; i < data_width; i++) begin : g_bit
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_WIDTH      (CNT_WIDTH)
    ) u_debounce (
      .clk     (clk),
      .rst     (rst),
      .i_btn   (i_btn_in[i]),
      .o_stable(w_stable[i]),
      .o_rise  (w_rise[i])
    );
  end

  assign w_sel = decode_addr(bus.addr, BASE_ADDR);

  // A new press outranks a clear of the same bit in the same cycle.
  always_comb begin
    w_clr_mask = '0;
    if (bus.write_en && (w_sel == SEL_EVENT)) begin
      w_clr_mask = bus.din;
    end
    w_event_next = (r_event & ~w_clr_mask) | w_rise;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_event      <= '0;
      r_event_pend <= 1'b0;
    end else begin
      r_event      <= w_event_next;
      r_event_pend <= |w_event_next;
    end
  end

  assign o_event_pend = r_event_pend;

  always_comb begin
    bus.dout = '0;
    case (w_sel)
      SEL_STATUS: bus.dout = w_stable;
      SEL_EVENT:  bus.dout = r_event;
      default:    bus.dout = '0;
    endcase
  end

endmodule
